// File: rtl/seq_divider.sv
// seq_divider: sequential signed divider, restoring division on magnitudes
//   with a final sign-fix cycle (inverse of the Booth radix-2 multiplier).
// Latency: start sampled at edge k -> busy high after edges k..k+WIDTH,
//   result registered at edge k+WIDTH+1 with a one-cycle done pulse.
// Backpressure: none; start while busy aborts and restarts, no done for the
//   aborted operation, quot/rem keep their previous values.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   start        load operands and begin a division (sampled every edge)
//   dividend     signed dividend, sampled on a start edge only
//   divisor      signed divisor, sampled on a start edge only
//   quot, rem    registered signed quotient / remainder
//   busy         operation in progress
//   done         one-cycle pulse, quot/rem valid in that cycle
//   div_by_zero  sticky flag for the last operation (divisor == 0)
//   overflow     sticky flag for the last operation (most-negative / -1)

module seq_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quot,
  output logic [WIDTH-1:0] rem,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic             overflow
);

  // Counter holds 0..WIDTH-1; one iteration per CALC cycle.
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t            state_q;
  logic              neg_quot_q;   // quotient sign: dividend MSB ^ divisor MSB
  logic              neg_rem_q;    // remainder takes the sign of the dividend
  logic [WIDTH-1:0]  dvs_mag_q;    // |divisor|
  logic [WIDTH-1:0]  dvd_q;        // raw dividend, needed for the /0 remainder
  logic [WIDTH-1:0]  p_q;          // partial remainder (see note on width below)
  logic [WIDTH-1:0]  q_q;          // dividend magnitude shifting out / quotient in
  logic [CW-1:0]     cnt_q;
  logic              dz_pend_q;    // classification captured at start, applied at FIX
  logic              ov_pend_q;

  logic [WIDTH-1:0]  quot_q;
  logic [WIDTH-1:0]  rem_q;
  logic              busy_q;
  logic              done_q;
  logic              dz_q;
  logic              ov_q;

  // Combinational next-step values for one restoring iteration and for FIX.
  logic [WIDTH:0]    p_shift;
  logic [WIDTH:0]    t_diff;
  logic [WIDTH-1:0]  p_d;
  logic [WIDTH-1:0]  q_d;
  logic [WIDTH-1:0]  quot_fix_d;
  logic [WIDTH-1:0]  rem_fix_d;
  logic [WIDTH-1:0]  dvd_mag_d;
  logic [WIDTH-1:0]  dvs_mag_d;

  // Magnitude of a two's-complement value. The most-negative value maps to
  // 2^(WIDTH-1), which is still representable as an unsigned WIDTH-bit value.
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? (~v + 1'b1) : v;
  endfunction

  always_comb begin
    dvd_mag_d = mag(dividend);
    dvs_mag_d = mag(divisor);

    // Shift {P, Q} left by one. The stored P is always < |divisor| <= 2^(WIDTH-1)
    // after a restore, so it fits in WIDTH bits; only the shifted value needs
    // the extra bit, and the subtract result's top bit is the borrow.
    p_shift = {p_q, q_q[WIDTH-1]};
    t_diff  = p_shift - {1'b0, dvs_mag_q};

    if (t_diff[WIDTH]) begin
      p_d = p_shift[WIDTH-1:0];      // restore
      q_d = {q_q[WIDTH-2:0], 1'b0};
    end else begin
      p_d = t_diff[WIDTH-1:0];
      q_d = {q_q[WIDTH-2:0], 1'b1};
    end

    quot_fix_d = neg_quot_q ? (~q_q + 1'b1) : q_q;
    rem_fix_d  = neg_rem_q  ? (~p_q + 1'b1) : p_q;

    // Special cases override the iterated result.
    if (dz_pend_q) begin
      quot_fix_d = '1;
      rem_fix_d  = dvd_q;
    end else if (ov_pend_q) begin
      quot_fix_d = MOST_NEG;
      rem_fix_d  = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      dvs_mag_q  <= '0;
      dvd_q      <= '0;
      p_q        <= '0;
      q_q        <= '0;
      cnt_q      <= '0;
      dz_pend_q  <= 1'b0;
      ov_pend_q  <= 1'b0;
      quot_q     <= '0;
      rem_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      dz_q       <= 1'b0;
      ov_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;

      // start has priority in every state: a start during CALC or on the FIX
      // edge silently abandons the running operation.
      if (start) begin
        state_q    <= S_CALC;
        neg_quot_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
        neg_rem_q  <= dividend[WIDTH-1];
        dvs_mag_q  <= dvs_mag_d;
        dvd_q      <= dividend;
        p_q        <= '0;
        q_q        <= dvd_mag_d;
        cnt_q      <= '0;
        dz_pend_q  <= (divisor == '0);
        ov_pend_q  <= (dividend == MOST_NEG) && (divisor == '1);
        busy_q     <= 1'b1;
        dz_q       <= 1'b0;
        ov_q       <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            busy_q <= 1'b0;
          end

          S_CALC: begin
            p_q   <= p_d;
            q_q   <= q_d;
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == LAST_ITER) begin
              state_q <= S_FIX;
            end
          end

          S_FIX: begin
            quot_q  <= quot_fix_d;
            rem_q   <= rem_fix_d;
            dz_q    <= dz_pend_q;
            ov_q    <= ov_pend_q;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end

          default: begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign quot        = quot_q;
  assign rem         = rem_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dz_q;
  assign overflow    = ov_q;

endmodule

// File: tb/tb_seq_divider.sv
module tb_seq_divider;

  localparam int W = 8;
  localparam int LAT = W + 1;   // edges after the start edge until done is seen

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic [W-1:0] quot;
  logic [W-1:0] rem;
  logic         busy;
  logic         done;
  logic         div_by_zero;
  logic         overflow;

  int checks;
  int failures;

  // Last committed result, to check that quot/rem hold across start/CALC.
  logic [W-1:0] prev_q;
  logic [W-1:0] prev_r;

  seq_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .quot        (quot),
    .rem         (rem),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: C-style truncating division on integers, plus the two
  // special cases.
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] q, output logic [W-1:0] r,
                                output logic dz, output logic ov);
    int sa;
    int sb;
    sa = int'($signed(a));
    sb = int'($signed(b));
    dz = 1'b0;
    ov = 1'b0;
    if (sb == 0) begin
      q  = '1;
      r  = a;
      dz = 1'b1;
    end else if (sa == -(1 << (W-1)) && sb == -1) begin
      q  = a;
      r  = '0;
      ov = 1'b1;
    end else begin
      q = W'(sa / sb);
      r = W'(sa % sb);
    end
  endfunction

  // Pulse start for one edge. Caller is positioned at a negedge.
  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(negedge clk);
    start    = 1'b0;
    // Operands must only be sampled on the start edge.
    dividend = W'($urandom);
    divisor  = W'($urandom);
  endtask

  // Full operation: launch, check hold/busy behaviour, latency, result, pulse.
  task automatic op(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] eq;
    logic [W-1:0] er;
    logic         edz;
    logic         eov;
    int           n;
    int           nbusy;
    model(a, b, eq, er, edz, eov);
    launch(a, b);
    chk("busy_after_start", {31'd0, busy}, 32'd1);
    chk("hold_during_calc", {16'd0, quot, rem}, {16'd0, prev_q, prev_r});
    chk("flags_cleared_at_start", {30'd0, div_by_zero, overflow}, 32'd0);
    n = 0;
    nbusy = (busy === 1'b1) ? 1 : 0;
    while (done !== 1'b1 && n < 4 * LAT) begin
      @(negedge clk);
      n++;
      if (busy === 1'b1) nbusy++;
    end
    chk("latency", n, LAT);
    chk("busy_cycles", nbusy, W + 1);
    chk("result", {14'd0, quot, rem, div_by_zero, overflow}, {14'd0, eq, er, edz, eov});
    @(negedge clk);
    chk("done_one_cycle", {30'd0, done, busy}, 32'd0);
    chk("flags_sticky", {30'd0, div_by_zero, overflow}, {30'd0, edz, eov});
    prev_q = eq;
    prev_r = er;
  endtask

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    logic         ov;
  } vec_t;

  vec_t dir[7];

  initial begin
    checks   = 0;
    failures = 0;
    prev_q   = '0;
    prev_r   = '0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    rst      = 1'b1;

    dir[0] = '{8'd100, 8'd7,   8'h0E, 8'h02, 1'b0, 1'b0};
    dir[1] = '{8'h9C,  8'd7,   8'hF2, 8'hFE, 1'b0, 1'b0};
    dir[2] = '{8'd100, 8'hF9,  8'hF2, 8'h02, 1'b0, 1'b0};
    dir[3] = '{8'h9C,  8'hF9,  8'h0E, 8'hFE, 1'b0, 1'b0};
    dir[4] = '{8'h80,  8'hFF,  8'h80, 8'h00, 1'b0, 1'b1};
    dir[5] = '{8'h80,  8'h01,  8'h80, 8'h00, 1'b0, 1'b0};
    dir[6] = '{8'd5,   8'h00,  8'hFF, 8'h05, 1'b1, 1'b0};

    #2;
    chk("reset_outputs", {13'd0, quot, rem, busy, done, div_by_zero, overflow}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Directed table, compared against hand-computed constants.
    for (int i = 0; i < 7; i++) begin
      op(dir[i].a, dir[i].b);
      chk("directed_const", {14'd0, quot, rem, div_by_zero, overflow},
          {14'd0, dir[i].q, dir[i].r, dir[i].dz, dir[i].ov});
    end

    // Abort during CALC: the first operation must never complete.
    launch(8'd100, 8'd7);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort_no_done", {31'd0, done}, 32'd0);
    end
    op(8'd50, 8'd3);
    chk("abort_second_result", {16'd0, quot, rem}, {16'd0, 8'd16, 8'd2});

    // Restart on the FIX edge: start wins, no done, results held.
    launch(8'd77, 8'd5);
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      chk("fix_restart_no_done", {31'd0, done}, 32'd0);
    end
    op(8'hC8, 8'd9);

    // Asynchronous reset mid-CALC clears outputs without a clock edge.
    launch(8'd120, 8'd11);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_reset_mid_calc", {13'd0, quot, rem, busy, done, div_by_zero, overflow}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    prev_q = '0;
    prev_r = '0;
    repeat (2 * LAT) begin
      @(negedge clk);
      chk("no_done_after_reset", {31'd0, done}, 32'd0);
    end

    // Random sweep, biased to hit zero, -1 and the most-negative value.
    for (int i = 0; i < 1500; i++) begin
      logic [W-1:0] a;
      logic [W-1:0] b;
      a = W'($urandom);
      b = W'($urandom);
      case ($urandom_range(0, 7))
        0: b = '0;
        1: b = '1;
        2: a = 8'h80;
        3: begin a = 8'h80; b = '1; end
        default: ;
      endcase
      op(a, b);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
